cic_integrator_chain: RTL and testbench

CIC_INTEGRATOR_CHAIN -- requirements
Module: cic_integrator_chain

---
 rtl/cic_integrator_chain.sv | 104 ++++++++++
 tb/tb_cic_integrator_chain.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cic_integrator_chain.sv
// Cascaded integrator chain for a CIC decimator/interpolator front end.
// Each stage accumulates the registered output of the stage before it, qualified by a
// valid bit that travels down the chain alongside the data. Overflow either wraps or
// saturates per stage, and any overflow raises a sticky flag until clr or reset.
module cic_integrator_chain #(
   parameter int unsigned IN_W    = 16,
   parameter int unsigned ACC_W   = 19,
   parameter int unsigned NSTAGES = 3,
   parameter int unsigned SAT     = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic signed [IN_W-1:0]  in,
   input  logic                    in_valid,
   output logic signed [ACC_W-1:0] out,
   output logic                    out_valid,
   output logic                    ovf
);

   localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W-1:0] acc_q [NSTAGES];
   logic signed [ACC_W-1:0] acc_d [NSTAGES];
   logic [NSTAGES-1:0]      v_q, v_d;
   logic                    ovf_q, ovf_d;

   logic signed [ACC_W-1:0] in_ext;
   logic signed [ACC_W-1:0] stage_res [NSTAGES];
   logic                    stage_en  [NSTAGES];
   logic                    stage_of  [NSTAGES];

   assign in_ext = ACC_W'(in);

   for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
      logic signed [ACC_W-1:0] opnd;
      logic signed [ACC_W-1:0] sum;

      if (k == 0) begin : g_first
         assign opnd        = in_ext;
         assign stage_en[k] = in_valid;
      end else begin : g_rest
         assign opnd        = acc_q[k-1];
         assign stage_en[k] = v_q[k-1];
      end

      assign sum = acc_q[k] + opnd;
      // Same-sign operands whose sum flips sign have left the ACC_W range.
      assign stage_of[k] = stage_en[k] && (acc_q[k][ACC_W-1] == opnd[ACC_W-1]) &&
                           (sum[ACC_W-1] != acc_q[k][ACC_W-1]);
      // The clamp direction follows the operands' shared sign.
      assign stage_res[k] = (stage_of[k] && (SAT != 0)) ?
                            (acc_q[k][ACC_W-1] ? AccMin : AccMax) : sum;
   end

   // Next state: clr wins, otherwise enabled stages accumulate and valids shift down.
   always_comb begin
      v_d   = v_q;
      ovf_d = ovf_q;
      for (int k = 0; k < NSTAGES; k++) begin
         acc_d[k] = acc_q[k];
      end
      if (clr) begin
         v_d   = '0;
         ovf_d = 1'b0;
         for (int k = 0; k < NSTAGES; k++) begin
            acc_d[k] = '0;
         end
      end else begin
         for (int k = 0; k < NSTAGES; k++) begin
            v_d[k] = stage_en[k];
            if (stage_en[k]) begin
               acc_d[k] = stage_res[k];
            end
            if (stage_of[k]) begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < NSTAGES; k++) begin
            acc_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         ovf_q <= ovf_d;
         for (int k = 0; k < NSTAGES; k++) begin
            acc_q[k] <= acc_d[k];
         end
      end
   end

   assign out       = acc_q[NSTAGES-1];
   assign out_valid = v_q[NSTAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Bench for cic_integrator_chain: three instances (default, 1-stage wrap, 1-stage saturate)
// share one stimulus stream and are compared every cycle against an arithmetic model.
module tb_cic_integrator_chain;

   localparam longint AMAX = 262143;
   localparam longint AMIN = -262144;

   logic clk = 1'b0;
   logic rst;
   logic clr;
   logic in_valid;
   logic signed [15:0] in_s;

   logic signed [18:0] out0, out1, out2;
   logic ov0, ov1, ov2;
   logic of0, of1, of2;

   int checks = 0;
   int failures = 0;

   longint macc [3][9];
   bit     mv   [3][9];
   bit     movf [3];
   int     mn   [3] = '{3, 1, 1};
   int     ms   [3] = '{0, 0, 1};

   longint imp_exp  [5] = '{1, 3, 6, 10, 15};
   longint step_exp [5] = '{1, 4, 10, 20, 35};

   always #5 clk = ~clk;

   cic_integrator_chain #(.IN_W(16), .ACC_W(19), .NSTAGES(3), .SAT(0)) u_def (
      .clk(clk), .rst(rst), .clr(clr), .in(in_s), .in_valid(in_valid),
      .out(out0), .out_valid(ov0), .ovf(of0));

   cic_integrator_chain #(.IN_W(16), .ACC_W(19), .NSTAGES(1), .SAT(0)) u_wrap (
      .clk(clk), .rst(rst), .clr(clr), .in(in_s), .in_valid(in_valid),
      .out(out1), .out_valid(ov1), .ovf(of1));

   cic_integrator_chain #(.IN_W(16), .ACC_W(19), .NSTAGES(1), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .clr(clr), .in(in_s), .in_valid(in_valid),
      .out(out2), .out_valid(ov2), .ovf(of2));

   function automatic longint wrap19(longint s);
      longint r;
      r = s & 64'h7FFFF;
      if (r > AMAX) r = r - 524288;
      return r;
   endfunction

   task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] req);
      checks++;
      assert (obs === req) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 3; m++) begin
         movf[m] = 1'b0;
         for (int k = 0; k < 9; k++) begin
            macc[m][k] = 0;
            mv[m][k]   = 1'b0;
         end
      end
   endtask

   // One clock edge of the spec: every stage adds its upstream value when upstream was valid.
   task automatic model_step(bit vld, longint x, bit c);
      longint oa [9];
      bit     ov [9];
      longint s;
      if (c) begin
         model_reset();
         return;
      end
      for (int m = 0; m < 3; m++) begin
         oa = macc[m];
         ov = mv[m];
         ov[0] = vld;
         for (int k = 1; k <= mn[m]; k++) begin
            if (ov[k-1]) begin
               s = oa[k] + ((k == 1) ? x : oa[k-1]);
               if (s > AMAX || s < AMIN) begin
                  movf[m] = 1'b1;
                  if (ms[m] != 0) s = (s > AMAX) ? AMAX : AMIN;
                  else            s = wrap19(s);
               end
               macc[m][k] = s;
            end
            mv[m][k] = ov[k-1];
         end
      end
   endtask

   task automatic check_model();
      chk("model_out0",  out0, macc[0][mn[0]]);
      chk("model_vld0",  ov0,  mv[0][mn[0]]);
      chk("model_ovf0",  of0,  movf[0]);
      chk("model_out1",  out1, macc[1][mn[1]]);
      chk("model_vld1",  ov1,  mv[1][mn[1]]);
      chk("model_ovf1",  of1,  movf[1]);
      chk("model_out2",  out2, macc[2][mn[2]]);
      chk("model_vld2",  ov2,  mv[2][mn[2]]);
      chk("model_ovf2",  of2,  movf[2]);
   endtask

   task automatic check_reset_zero(string tag);
      chk({tag, "_out0"}, out0, 0);
      chk({tag, "_vld0"}, ov0,  0);
      chk({tag, "_ovf0"}, of0,  0);
      chk({tag, "_out1"}, out1, 0);
      chk({tag, "_vld1"}, ov1,  0);
      chk({tag, "_ovf1"}, of1,  0);
      chk({tag, "_out2"}, out2, 0);
      chk({tag, "_vld2"}, ov2,  0);
      chk({tag, "_ovf2"}, of2,  0);
   endtask

   task automatic cyc(bit vld, longint x, bit c);
      in_valid = vld;
      in_s     = x[15:0];
      clr      = c;
      @(posedge clk);
      model_step(vld, x, c);
      #1;
      check_model();
   endtask

   initial begin
      logic signed [15:0] r;
      bit rv, rc;

      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_s = '0;
      model_reset();
      #1 rst = 1'b0;
      #1 check_reset_zero("por");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Impulse through the default 3-stage chain.
      for (int i = 1; i <= 7; i++) begin
         cyc(1'b1, (i == 1) ? 1 : 0, 1'b0);
         if (i == 2) chk("impulse_latency", ov0, 0);
         if (i >= 3) begin
            chk("impulse_out", out0, imp_exp[i-3]);
            chk("impulse_vld", ov0, 1);
         end
      end
      cyc(1'b0, 0, 1'b1);

      // Step up, then step down with negative input.
      for (int i = 1; i <= 7; i++) begin
         cyc(1'b1, 1, 1'b0);
         if (i >= 3) chk("step_out", out0, step_exp[i-3]);
      end
      for (int i = 0; i < 6; i++) cyc(1'b1, -1, 1'b0);
      cyc(1'b0, 0, 1'b1);

      // Full-scale input: wrap on instance 1, clamp on instance 2.
      for (int i = 1; i <= 10; i++) begin
         cyc(1'b1, 32767, 1'b0);
         if (i == 8) begin
            chk("wrap_8th", out1, 262136);
            chk("wrap_ovf_clear", of1, 0);
            chk("sat_8th", out2, 262136);
         end
         if (i == 9) begin
            chk("wrap_9th", out1, -229385);
            chk("wrap_ovf", of1, 1);
            chk("sat_9th", out2, 262143);
            chk("sat_ovf", of2, 1);
         end
         if (i == 10) chk("sat_10th", out2, 262143);
      end
      cyc(1'b0, 0, 1'b1);
      chk("sat_clr_out", out2, 0);
      chk("sat_clr_ovf", of2, 0);
      chk("sat_clr_vld", ov2, 0);

      // Alternating valid with in=2: single stage holds through bubbles.
      for (int i = 1; i <= 8; i++) begin
         cyc(i[0], 2, 1'b0);
         chk("gap_vld", ov1, i[0]);
         chk("gap_out", out1, 2 * ((i + 1) / 2));
      end

      // clr with a valid input discards it and everything in flight.
      cyc(1'b1, 2, 1'b0);
      cyc(1'b1, 2, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 0, 1'b0);
         chk("clr_no_vld", ov0, 0);
      end

      // Asynchronous reset mid-stream, then first output NSTAGES edges after next input.
      for (int i = 0; i < 4; i++) cyc(1'b1, 5, 1'b0);
      #3 rst = 1'b0;
      #1 check_reset_zero("async_rst");
      model_reset();
      @(posedge clk);
      #1 check_model();
      rst = 1'b1;
      cyc(1'b1, 7, 1'b0);
      cyc(1'b0, 0, 1'b0);
      chk("rst_relat_early", ov0, 0);
      cyc(1'b0, 0, 1'b0);
      chk("rst_relat_vld", ov0, 1);
      chk("rst_relat_out", out0, 7);

      // Randomized traffic with occasional clears.
      for (int i = 0; i < 400; i++) begin
         r  = 16'($urandom);
         rv = 1'($urandom_range(0, 1));
         rc = ($urandom_range(0, 31) == 0);
         cyc(rv, r, rc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
